// File: rtl/spike_rate_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : spike_rate_decoder_pkg
// Brief  : Shared neuron-decoder types, default widths and constants.
// Rev    : 1.0
// ============================================================================
package spike_rate_decoder_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  localparam int WIN_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  // Reported as first-spike latency when a window saw no spike.
  localparam logic [WIN_W_DEF-1:0] LAT_NONE = '1;

endpackage : spike_rate_decoder_pkg
`default_nettype wire

// File: rtl/spike_rate_decoder_edge_detect.sv
`default_nettype none
// ============================================================================
// Module : spike_edge_detect
// Brief  : Registers the spike line and flags its rising edges as events.
// Rev    : 1.0
// ============================================================================
module spike_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic spike_i,
  output logic event_o
);

  logic spike_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
    end else begin
      spike_q <= spike_i;
    end
  end

  assign event_o = spike_i & ~spike_q;

endmodule : spike_edge_detect
`default_nettype wire

// File: rtl/spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module : spike_rate_decoder
// Brief  : Decodes a neuron spike train into spike count and first-spike
//          latency per window, delivered through a one-entry valid/ready buffer.
// Rev    : 1.0
// ============================================================================
module spike_rate_decoder
  import spike_rate_decoder_pkg::*;
#(
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [WIN_W-1:0] first_lat,
  output logic             no_spike,
  output logic             sat,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] idx_q, idx_d;
  logic [WIN_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             sat_int_q, sat_int_d;

  logic [CNT_W-1:0] rate_q, rate_d;
  logic [WIN_W-1:0] first_lat_q, first_lat_d;
  logic             no_spike_q, no_spike_d;
  logic             sat_q, sat_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             spike_event;
  logic             win_end;
  logic [CNT_W-1:0] cnt_fin;
  logic [WIN_W-1:0] lat_fin;
  logic             seen_fin;
  logic             sat_fin;
  logic [WIN_W-1:0] win_len_m1;

  spike_edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike_i (spike_in),
    .event_o (spike_event)
  );

  // window_len of 0 wraps to all-ones, giving a full 2^WIN_W cycle window.
  assign win_len_m1 = window_len - WIN_W'(1);
  assign win_end    = (state_q == COUNT) && (win_cnt_q == '0);

  // Window totals including the current cycle's event, used at window end.
  always_comb begin
    cnt_fin  = (spike_event && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    sat_fin  = sat_int_q | (spike_event & (cnt_q == CNT_MAX));
    seen_fin = seen_q | spike_event;
    lat_fin  = (spike_event && !seen_q) ? idx_q : lat_q;
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    idx_d     = idx_q;
    lat_d     = lat_q;
    cnt_d     = cnt_q;
    seen_d    = seen_q;
    sat_int_d = sat_int_q;
    case (state_q)
      IDLE: begin
        if (ena) begin
          state_d   = COUNT;
          win_cnt_d = win_len_m1;
          idx_d     = '0;
          lat_d     = '1;
          cnt_d     = '0;
          seen_d    = 1'b0;
          sat_int_d = 1'b0;
        end
      end
      COUNT: begin
        if (win_end) begin
          // Back-to-back windows restart here with no gap cycle.
          if (ena) begin
            win_cnt_d = win_len_m1;
            idx_d     = '0;
            lat_d     = '1;
            cnt_d     = '0;
            seen_d    = 1'b0;
            sat_int_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (!ena) begin
          state_d = IDLE;
        end else begin
          cnt_d     = cnt_fin;
          sat_int_d = sat_fin;
          seen_d    = seen_fin;
          lat_d     = lat_fin;
          idx_d     = idx_q + WIN_W'(1);
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rate_d      = rate_q;
    first_lat_d = first_lat_q;
    no_spike_d  = no_spike_q;
    sat_d       = sat_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    if (win_end) begin
      rate_d      = cnt_fin;
      first_lat_d = seen_fin ? lat_fin : '1;
      no_spike_d  = ~seen_fin;
      sat_d       = sat_fin;
      valid_d     = 1'b1;
      if (valid_q && !rate_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rate_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      idx_q       <= '0;
      lat_q       <= '1;
      cnt_q       <= '0;
      seen_q      <= 1'b0;
      sat_int_q   <= 1'b0;
      rate_q      <= '0;
      first_lat_q <= '1;
      no_spike_q  <= 1'b0;
      sat_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      idx_q       <= idx_d;
      lat_q       <= lat_d;
      cnt_q       <= cnt_d;
      seen_q      <= seen_d;
      sat_int_q   <= sat_int_d;
      rate_q      <= rate_d;
      first_lat_q <= first_lat_d;
      no_spike_q  <= no_spike_d;
      sat_q       <= sat_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rate_out   = rate_q;
  assign first_lat  = first_lat_q;
  assign no_spike   = no_spike_q;
  assign sat        = sat_q;
  assign rate_valid = valid_q;
  assign overrun    = overrun_q;

endmodule : spike_rate_decoder
`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
`default_nettype none
// ============================================================================
// Module : tb_spike_rate_decoder
// Brief  : Directed bench for spike_rate_decoder (8-bit and 2-bit counters).
// Rev    : 1.0
// ============================================================================
module tb_spike_rate_decoder;
  import spike_rate_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       spike_in = 1'b0;
  logic [7:0] window_len = 8'd0;
  logic       rate_ready = 1'b0;

  logic [7:0] a_rate, a_lat, b_lat;
  logic [1:0] b_rate;
  logic       a_nos, a_sat, a_valid, a_ovr;
  logic       b_nos, b_sat, b_valid, b_ovr;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.WIN_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .window_len(window_len), .rate_out(a_rate), .first_lat(a_lat),
    .no_spike(a_nos), .sat(a_sat), .rate_valid(a_valid),
    .rate_ready(rate_ready), .overrun(a_ovr)
  );

  spike_rate_decoder #(.WIN_W(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .window_len(window_len), .rate_out(b_rate), .first_lat(b_lat),
    .no_spike(b_nos), .sat(b_sat), .rate_valid(b_valid),
    .rate_ready(rate_ready), .overrun(b_ovr)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  // Window-level model: collect events per window, summarise at the end.
  bit m_active = 0, m_prev = 0, m_ev = 0;
  int m_len = 0, m_pos = 0, m_events = 0, m_first = -1;
  int e_rate[2] = '{0, 0};
  int e_sat[2]  = '{0, 0};
  int e_lat = 255, e_nos = 0, e_valid = 0, e_ovr = 0;

  task automatic m_start();
    m_active = 1;
    m_len    = (window_len == 0) ? 256 : int'(window_len);
    m_pos    = 0;
    m_events = 0;
    m_first  = -1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_prev = 0;
      e_rate[0] = 0; e_rate[1] = 0; e_sat[0] = 0; e_sat[1] = 0;
      e_lat = 255; e_nos = 0; e_valid = 0; e_ovr = 0;
    end else begin
      m_ev   = spike_in && !m_prev;
      m_prev = spike_in;
      if (!m_active) begin
        if (ena) m_start();
        if (e_valid && rate_ready) e_valid = 0;
      end else begin
        if (m_ev) begin
          m_events++;
          if (m_first < 0) m_first = m_pos;
        end
        if (m_pos == m_len - 1) begin
          if (e_valid && !rate_ready) e_ovr = 1;
          e_valid   = 1;
          e_rate[0] = (m_events > 255) ? 255 : m_events;
          e_rate[1] = (m_events > 3) ? 3 : m_events;
          e_sat[0]  = (m_events > 255) ? 1 : 0;
          e_sat[1]  = (m_events > 3) ? 1 : 0;
          e_lat     = (m_first < 0) ? int'(LAT_NONE) : m_first;
          e_nos     = (m_events == 0) ? 1 : 0;
          if (ena) m_start();
          else m_active = 0;
        end else begin
          if (e_valid && rate_ready) e_valid = 0;
          if (!ena) m_active = 0;
          else m_pos++;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("A.rate_out",   int'(a_rate),  e_rate[0]);
    chk("A.first_lat",  int'(a_lat),   e_lat);
    chk("A.no_spike",   int'(a_nos),   e_nos);
    chk("A.sat",        int'(a_sat),   e_sat[0]);
    chk("A.rate_valid", int'(a_valid), e_valid);
    chk("A.overrun",    int'(a_ovr),   e_ovr);
    chk("B.rate_out",   int'(b_rate),  e_rate[1]);
    chk("B.first_lat",  int'(b_lat),   e_lat);
    chk("B.sat",        int'(b_sat),   e_sat[1]);
    chk("B.no_spike",   int'(b_nos),   e_nos);
    chk("B.rate_valid", int'(b_valid), e_valid);
    chk("B.overrun",    int'(b_ovr),   e_ovr);
  end

  task automatic step(input logic e, input logic s, input logic [7:0] wl, input logic r);
    @(negedge clk);
    ena = e; spike_in = s; window_len = wl; rate_ready = r;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  pat8;
    logic [3:0]  pat4;
    repeat (3) @(negedge clk);
    chk("reset rate_out",  int'(a_rate),  0);
    chk("reset first_lat", int'(a_lat),   255);
    chk("reset valid",     int'(a_valid), 0);
    rst_n = 1'b1;

    // Basic rate/latency: spikes on odd cycles of an 8-cycle window.
    pat8 = 8'b1010_1010;
    step(1, 0, 8, 0);
    for (int i = 0; i < 8; i++) step(1, pat8[i], 8, 0);
    settle();
    chk("basic rate_out",  int'(a_rate),  4);
    chk("basic first_lat", int'(a_lat),   1);
    chk("basic no_spike",  int'(a_nos),   0);
    chk("basic sat",       int'(a_sat),   0);
    chk("basic valid",     int'(a_valid), 1);
    step(0, 0, 8, 1);

    // Silent window.
    step(1, 0, 4, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 4, 0);
    settle();
    chk("silent rate_out",  int'(a_rate), 0);
    chk("silent first_lat", int'(a_lat),  255);
    chk("silent no_spike",  int'(a_nos),  1);
    step(0, 0, 4, 1);

    // Held level counts once.
    step(1, 0, 8, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 8, 1);
    settle();
    chk("held rate_out",  int'(a_rate), 1);
    chk("held first_lat", int'(a_lat),  0);
    step(0, 0, 8, 1);

    // Saturation of the 2-bit counter on a 16-cycle toggle window.
    step(1, 0, 16, 1);
    for (int i = 0; i < 16; i++) step(1, ((i % 2) == 0), 16, 1);
    settle();
    chk("satur B.rate_out", int'(b_rate), 3);
    chk("satur B.sat",      int'(b_sat),  1);
    chk("satur A.rate_out", int'(a_rate), 8);
    step(0, 0, 16, 1);

    // Back-to-back windows with the consumer stalled.
    pat4 = 4'b0001;
    step(1, 0, 4, 0);
    for (int i = 0; i < 4; i++) step(1, pat4[i], 4, 0);
    settle();
    chk("b2b first overrun", int'(a_ovr),  0);
    chk("b2b first rate",    int'(a_rate), 1);
    pat4 = 4'b1010;
    for (int i = 0; i < 4; i++) step(1, pat4[i], 4, 0);
    settle();
    chk("b2b overrun",   int'(a_ovr),   1);
    chk("b2b rate_out",  int'(a_rate),  2);
    chk("b2b first_lat", int'(a_lat),   1);
    chk("b2b valid",     int'(a_valid), 1);
    step(0, 0, 4, 1);
    step(0, 0, 4, 0);
    settle();
    chk("drain valid",   int'(a_valid), 0);
    chk("drain overrun", int'(a_ovr),   1);

    // Abort at window cycle 3 of 8.
    step(1, 0, 8, 0);
    step(1, 1, 8, 0);
    step(1, 0, 8, 0);
    step(1, 1, 8, 0);
    step(0, 0, 8, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8, 0);
    settle();
    chk("abort valid",     int'(a_valid), 0);
    chk("abort rate_out",  int'(a_rate),  2);
    chk("abort first_lat", int'(a_lat),   1);

    // Asynchronous reset in the middle of a window.
    step(1, 0, 8, 0);
    step(1, 1, 8, 0);
    step(1, 1, 8, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    ena = 1'b0; spike_in = 1'b0;
    #1;
    chk("async rst overrun",   int'(a_ovr),  0);
    chk("async rst rate_out",  int'(a_rate), 0);
    chk("async rst first_lat", int'(a_lat),  255);
    @(negedge clk);
    rst_n = 1'b1;

    // Window length 1.
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(1, 1, 1, 1);
    settle();
    chk("len1 rate_out",  int'(a_rate), 1);
    chk("len1 first_lat", int'(a_lat),  0);
    step(1, 1, 1, 1);
    settle();
    chk("len1 held rate", int'(a_rate), 0);
    chk("len1 held lat",  int'(a_lat),  255);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule : tb_spike_rate_decoder
`default_nettype wire

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiving end of the neuron spike interface: consumes the single-bit spike output of a neuron and decodes it back into numbers once per window.
- Two numbers are produced per fixed-length observation window: spike count (rate code) and time-to-first-spike (latency code).
- Results are delivered through a one-entry valid/ready output buffer, so a host or downstream logic can read neuron activity without cycle-exact sampling.

Parameters:
- WIN_W, 8, width of window_len; window length up to 2^WIN_W cycles.
- CNT_W, 8, width of rate_out; the counter saturates at 2^CNT_W-1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- ena  input  1  decoder enable; low aborts any window in progress.
- spike_in  input  1  neuron spike output, synchronous to clk.
- window_len  input  WIN_W  window length in cycles; 0 means 2^WIN_W; sampled only at window start.
- rate_out  output  CNT_W  spike count of the last completed window.
- first_lat  output  WIN_W  0-based cycle index of the first spike in that window; all-ones if none.
- no_spike  output  1  last window contained no spike.
- sat  output  1  spike count saturated in last window.
- rate_valid  output  1  result buffer full.
- rate_ready  input  1  consumer accepts the result when rate_valid and rate_ready are both high at a clk edge.
- overrun  output  1  sticky: a result was overwritten before being accepted.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0 except first_lat, which resets to all-ones; spike_d=0.
- Spike event = spike_in & ~spike_d, where spike_d is spike_in registered. spike_d updates every cycle regardless of state.
  - A level held high counts once.
  - A spike already high at window start does not count unless spike_d was 0 on the previous cycle.
- States: IDLE, COUNT.
- IDLE:
  - When ena=1, load win_cnt = window_len-1 (all-ones if window_len=0).
  - Clear cnt and idx, set seen=0, go to COUNT.
  - The first window cycle is the next cycle.
- COUNT, each cycle:
  - Event counting: if an event occurs and cnt is below max, increment cnt. If an event occurs and cnt is at max, set sat_int.
  - First spike: if an event occurs and seen=0, latch lat=idx and set seen=1.
  - Advance: idx increments and win_cnt decrements.
  - Window end: when win_cnt=0, that cycle's event is included in the result. At the same edge the result registers load:
    - rate_out = final cnt
    - first_lat = lat, or all-ones if no event
    - no_spike = ~seen
    - sat
    - rate_valid=1
  - After window end: if ena=1, the next window starts immediately. window_len is resampled, counters are cleared and the state stays COUNT, with no gap cycle. If ena=0, go to IDLE.
- ena=0 mid-window: the partial window is discarded and the state returns to IDLE on the next edge. The output buffer and overrun are unaffected.
- Output handshake:
  - rate_valid clears on the edge where rate_valid & rate_ready.
  - Result outputs hold stable while rate_valid=1 and no new result loads.
- Simultaneous load and accept (rate_ready=1 on the load edge): the new result loads, rate_valid stays 1, no overrun.
- Load while rate_valid=1 and rate_ready=0: the new result overwrites the old one and overrun is set. overrun is cleared only by reset.
- Window length 1: every cycle is its own window; rate_out is 0 or 1, and first_lat is 0 or all-ones.
- Latency: result visible 1 cycle after the last window cycle.

Decomposition:
- Shared neuron package holds:
  - state enum (IDLE, COUNT)
  - WIN_W/CNT_W defaults
  - the all-ones LAT_NONE constant, which the neuron testbench also uses.
- One natural sub-module, spike_edge_detect (spike_d register plus event output), reused by future multi-neuron decoders.
- Counter, state machine and output buffer stay in the top.

Test Plan:
- Basic rate/latency: window_len=8, spike_in over window cycles 0..7 = 0,1,0,1,0,1,0,1 (spike_d=0 before) -> rate_out=4, first_lat=1, no_spike=0, sat=0, rate_valid=1 the cycle after cycle 7.
- Silent window: window_len=4, spike_in=0 throughout -> rate_out=0, first_lat=8'hFF, no_spike=1.
- Held level plus saturation:
  - Held level: spike_in high for all 8 cycles of an 8-cycle window, rising at cycle 0 -> rate_out=1, first_lat=0.
  - Saturation: CNT_W=2, window_len=16 with a toggle every cycle -> rate_out=3, sat=1.
- Back-to-back plus overrun:
  - ena=1, window_len=4, rate_ready=0 across two windows -> second result overwrites the first and overrun=1.
  - Then pulse rate_ready for one cycle -> rate_valid=0.
- Abort and reset:
  - ena dropped at window cycle 3 of 8 -> no new result, state IDLE, previous result intact.
  - rst_n asserted mid-window -> all outputs go to reset values immediately, without waiting for clk.
